// File: rtl/mips_data_mem_responder_pkg.sv
// mips_mem_pkg: byte-enable encodings, legality check and trace-entry type for the data-memory responder.
package mips_mem_pkg;
   localparam logic [3:0] BE_NONE = 4'b0000;
   localparam logic [3:0] BE_B0   = 4'b0001;
   localparam logic [3:0] BE_B1   = 4'b0010;
   localparam logic [3:0] BE_B2   = 4'b0100;
   localparam logic [3:0] BE_B3   = 4'b1000;
   localparam logic [3:0] BE_H0   = 4'b0011;
   localparam logic [3:0] BE_H1   = 4'b1100;
   localparam logic [3:0] BE_W    = 4'b1111;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  byteen;
   } mem_log_t;

   function automatic logic be_legal(input logic [3:0] be);
      return be inside {BE_NONE, BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_W};
   endfunction
endpackage

// File: rtl/mips_data_mem_responder_sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers; push is honoured when full if a pop happens the same cycle.
module sync_fifo #(
   parameter type T = logic [7:0],
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  T                         pushData,
   input  logic                     pop,
   output T                         popData,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   T mem [DEPTH];
   logic [AW:0] wrPtr, rdPtr;
   logic doPush, doPop;
   assign empty = wrPtr == rdPtr;
   assign full = (wrPtr[AW-1:0] == rdPtr[AW-1:0]) && (wrPtr[AW] != rdPtr[AW]);
   assign count = wrPtr - rdPtr;
   assign doPop = pop && !empty;
   assign doPush = push && (!full || doPop);
   // Head is forced to zero when empty so consumers never see stale entries.
   assign popData = empty ? '0 : mem[rdPtr[AW-1:0]];
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + (AW+1)'(1);
         if (doPop) rdPtr <= rdPtr + (AW+1)'(1);
      end
   end
   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
   end
endmodule

// File: rtl/mips_data_mem_responder.sv
// mips_data_mem_responder: byte-enabled word RAM for the CPU M-stage port, with a store-trace FIFO and sticky error flags.
module mips_data_mem_responder
   import mips_mem_pkg::*;
#(
   parameter int MEM_AW = 12,
   parameter int LOG_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] m_data_addr,
   input  logic [31:0] m_data_wdata,
   input  logic [3:0]  m_data_byteen,
   input  logic [31:0] m_inst_addr,
   output logic [31:0] m_data_rdata,
   output logic        log_valid,
   input  logic        log_ready,
   output logic [31:0] log_pc,
   output logic [31:0] log_addr,
   output logic [31:0] log_data,
   output logic [3:0]  log_byteen,
   output logic        log_overflow,
   output logic        err_oob,
   output logic        err_byteen
);
   localparam int CW = $clog2(LOG_DEPTH) + 1;
   logic [31:0] mem [2**MEM_AW];
   logic [MEM_AW-1:0] wordIdx;
   logic inRange, beOk, accept, logPop, logFull, logEmpty;
   logic [31:0] oldWord, merged;
   logic [CW-1:0] logCount;
   mem_log_t pushEntry, headEntry;
   assign wordIdx = m_data_addr[MEM_AW+1:2];
   assign inRange = m_data_addr[31:MEM_AW+2] == '0;
   assign oldWord = mem[wordIdx];
   assign m_data_rdata = inRange ? oldWord : '0;
   assign beOk = be_legal(m_data_byteen);
   assign accept = (m_data_byteen != BE_NONE) && inRange && beOk;
   always_comb begin
      merged = oldWord;
      for (int i = 0; i < 4; i++)
         merged[8*i+:8] = m_data_byteen[i] ? m_data_wdata[8*i+:8] : oldWord[8*i+:8];
   end
   assign pushEntry = '{pc: m_inst_addr, addr: m_data_addr & ~32'h3, data: merged, byteen: m_data_byteen};
   assign log_valid = !logEmpty;
   assign logPop = log_valid && log_ready;
   assign {log_pc, log_addr, log_data, log_byteen} = headEntry;
   sync_fifo #(.T(mem_log_t), .DEPTH(LOG_DEPTH)) logFifo (
      .clk      (clk),
      .reset    (reset),
      .push     (accept),
      .pushData (pushEntry),
      .pop      (logPop),
      .popData  (headEntry),
      .full     (logFull),
      .empty    (logEmpty),
      .count    (logCount)
   );
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         for (int i = 0; i < 2**MEM_AW; i++) mem[i] <= '0;
      else if (accept)
         mem[wordIdx] <= merged;
   end
   // Every cycle presents an address, so an out-of-range address counts even without a store.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         log_overflow <= 1'b0;
         err_oob <= 1'b0;
         err_byteen <= 1'b0;
      end else begin
         if (accept && logFull && !logPop) log_overflow <= 1'b1;
         if (!inRange) err_oob <= 1'b1;
         if (!beOk) err_byteen <= 1'b1;
      end
   end
   always_comb begin
      if (reset) assert (logCount <= CW'(LOG_DEPTH));
   end
endmodule

// File: tb/tb_mips_data_mem_responder.sv
// tb_mips_data_mem_responder: directed stores/drains against a queue-and-array reference model checked every cycle.
module tb_mips_data_mem_responder;
   localparam int MEM_AW = 12;
   localparam int DEPTH = 8;

   typedef struct {
      bit [31:0] pc;
      bit [31:0] addr;
      bit [31:0] data;
      bit [3:0]  be;
   } ent_t;

   logic clk = 0;
   logic reset = 0;
   logic [31:0] mAddr = 0, mWdata = 0, mPc = 0;
   logic [3:0] mBe = 0;
   logic ready = 0;
   logic [31:0] rdata, logPc, logAddr, logData;
   logic [3:0] logBe;
   logic logValid, logOvf, errOob, errBe;

   int total = 0;
   int bad = 0;

   bit [31:0] mm [2**MEM_AW];
   ent_t q[$];
   bit ovf, oob, bee;
   bit inr, leg, doPop;
   int sz;
   bit [31:0] w, mask;

   mips_data_mem_responder #(.MEM_AW(MEM_AW), .LOG_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .m_data_addr  (mAddr),
      .m_data_wdata (mWdata),
      .m_data_byteen(mBe),
      .m_inst_addr  (mPc),
      .m_data_rdata (rdata),
      .log_valid    (logValid),
      .log_ready    (ready),
      .log_pc       (logPc),
      .log_addr     (logAddr),
      .log_data     (logData),
      .log_byteen   (logBe),
      .log_overflow (logOvf),
      .err_oob      (errOob),
      .err_byteen   (errBe)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit in_range(input bit [31:0] a);
      return (a >> (MEM_AW + 2)) == 0;
   endfunction

   // Reference model: plain array + queue, updated on each edge from the inputs held across it.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         foreach (mm[i]) mm[i] = 0;
         q.delete();
         ovf = 0;
         oob = 0;
         bee = 0;
      end else begin
         inr = in_range(mAddr);
         leg = mBe == 4'h0 || mBe == 4'h1 || mBe == 4'h2 || mBe == 4'h4 || mBe == 4'h8
               || mBe == 4'h3 || mBe == 4'hC || mBe == 4'hF;
         if (!inr) oob = 1;
         if (!leg) bee = 1;
         sz = q.size();
         doPop = sz > 0 && ready;
         if (doPop) q.delete(0);
         if (mBe != 0 && inr && leg) begin
            mask = {{8{mBe[3]}}, {8{mBe[2]}}, {8{mBe[1]}}, {8{mBe[0]}}};
            w = (mm[mAddr >> 2] & ~mask) | (mWdata & mask);
            mm[mAddr >> 2] = w;
            if (sz == DEPTH && !doPop) ovf = 1;
            else q.push_back('{mPc, mAddr & 32'hFFFF_FFFC, w, mBe});
         end
      end
   end

   always @(negedge clk) begin
      chk("rdata", rdata, in_range(mAddr) ? mm[mAddr >> 2] : 32'h0);
      chk("log_valid", 32'(logValid), 32'(q.size() > 0));
      chk("log_pc", logPc, q.size() > 0 ? q[0].pc : 32'h0);
      chk("log_addr", logAddr, q.size() > 0 ? q[0].addr : 32'h0);
      chk("log_data", logData, q.size() > 0 ? q[0].data : 32'h0);
      chk("log_byteen", 32'(logBe), q.size() > 0 ? 32'(q[0].be) : 32'h0);
      chk("log_overflow", 32'(logOvf), 32'(ovf));
      chk("err_oob", 32'(errOob), 32'(oob));
      chk("err_byteen", 32'(errBe), 32'(bee));
   end

   task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] b,
                        input logic [31:0] p, input logic r);
      @(posedge clk);
      #1;
      mAddr = a;
      mWdata = wd;
      mBe = b;
      mPc = p;
      ready = r;
   endtask

   initial begin
      logic [31:0] drainExp [8];
      drainExp = '{32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'h99};
      repeat (2) @(posedge clk);
      #1 reset = 1;
      @(negedge clk);
      chk("lit reset valid", 32'(logValid), 32'h0);
      chk("lit reset data", logData, 32'h0);
      // word store and readback
      drive(32'h10, 32'h12345678, 4'hF, 32'h3000, 0);
      drive(32'h10, 0, 0, 0, 0);
      @(negedge clk);
      chk("lit sw rdata", rdata, 32'h12345678);
      chk("lit sw log_pc", logPc, 32'h3000);
      chk("lit sw log_addr", logAddr, 32'h10);
      chk("lit sw log_byteen", 32'(logBe), 32'hF);
      // byte then halfword merges
      drive(32'h11, 32'hAAAAAAAA, 4'b0010, 32'h3004, 0);
      drive(32'h12, 32'hBEEF0000, 4'b1100, 32'h3008, 0);
      @(negedge clk);
      chk("lit sb merged", rdata, 32'h1234AA78);
      drive(32'h10, 0, 0, 0, 1);
      @(negedge clk);
      chk("lit sh merged", rdata, 32'hBEEFAA78);
      chk("lit drain0", logData, 32'h12345678);
      drive(32'h10, 0, 0, 0, 1);
      @(negedge clk);
      chk("lit drain1 data", logData, 32'h1234AA78);
      chk("lit drain1 addr", logAddr, 32'h10);
      chk("lit drain1 be", 32'(logBe), 32'h2);
      drive(32'h10, 0, 0, 0, 1);
      @(negedge clk);
      chk("lit drain2 data", logData, 32'hBEEFAA78);
      chk("lit drain2 pc", logPc, 32'h3008);
      drive(32'h10, 0, 0, 0, 0);
      @(negedge clk);
      chk("lit drained valid", 32'(logValid), 32'h0);
      // fill, push+pop while full, then overflow
      for (int i = 0; i < DEPTH; i++) drive(32'h20, 32'(i + 1), 4'hF, 32'h4000 + 32'(4 * i), 0);
      drive(32'h20, 32'h99, 4'hF, 32'h5000, 1);
      @(negedge clk);
      chk("lit full no ovf", 32'(logOvf), 32'h0);
      chk("lit full head", logData, 32'h1);
      drive(32'h20, 32'hA, 4'hF, 32'h5004, 0);
      @(negedge clk);
      chk("lit pushpop no ovf", 32'(logOvf), 32'h0);
      chk("lit pushpop head", logData, 32'h2);
      chk("lit pushpop ram", rdata, 32'h99);
      drive(32'h20, 0, 0, 0, 1);
      @(negedge clk);
      chk("lit ovf set", 32'(logOvf), 32'h1);
      chk("lit ovf ram last", rdata, 32'hA);
      chk("lit ovf drain0", logData, drainExp[0]);
      for (int k = 1; k < DEPTH; k++) begin
         drive(32'h20, 0, 0, 0, 1);
         @(negedge clk);
         chk($sformatf("lit ovf drain%0d", k), logData, drainExp[k]);
      end
      drive(32'h20, 0, 0, 0, 0);
      @(negedge clk);
      chk("lit ovf drained", 32'(logValid), 32'h0);
      // out-of-range and illegal byteen stores
      drive(32'h0001_0000, 32'hDEADBEEF, 4'hF, 32'h6000, 0);
      @(negedge clk);
      chk("lit oob rdata", rdata, 32'h0);
      drive(32'h10, 0, 0, 0, 0);
      @(negedge clk);
      chk("lit oob flag", 32'(errOob), 32'h1);
      chk("lit oob no log", 32'(logValid), 32'h0);
      chk("lit oob ram kept", rdata, 32'hBEEFAA78);
      drive(32'h0, 0, 0, 0, 0);
      @(negedge clk);
      chk("lit oob word0", rdata, 32'h0);
      drive(32'h10, 32'hFFFFFFFF, 4'b0110, 32'h6004, 0);
      drive(32'h10, 0, 0, 0, 0);
      @(negedge clk);
      chk("lit be flag", 32'(errBe), 32'h1);
      chk("lit be ram kept", rdata, 32'hBEEFAA78);
      chk("lit be no log", 32'(logValid), 32'h0);
      // async reset mid-drain
      drive(32'h30, 32'h11, 4'hF, 32'h7000, 0);
      drive(32'h30, 32'h22, 4'hF, 32'h7004, 0);
      drive(32'h30, 32'h33, 4'hF, 32'h7008, 0);
      drive(32'h30, 0, 0, 0, 1);
      #2 reset = 0;
      #1;
      chk("lit rst valid", 32'(logValid), 32'h0);
      chk("lit rst rdata", rdata, 32'h0);
      chk("lit rst ovf", 32'(logOvf), 32'h0);
      chk("lit rst oob", 32'(errOob), 32'h0);
      chk("lit rst be", 32'(errBe), 32'h0);
      @(posedge clk);
      #1 reset = 1;
      drive(32'h30, 0, 0, 0, 0);
      @(negedge clk);
      chk("lit post rst valid", 32'(logValid), 32'h0);
      chk("lit post rst rdata", rdata, 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
